// File: rtl/i2c_slave_ctrl_if.sv
// Byte-level handshake between the I2C responder and its client logic.
// The serial pins stay as plain ports on the responder; this bundle carries
// the parallel data and status side.
interface i2c_slave_ctrl_if;
  logic [7:0] iw_tx_data;
  logic       ow_tx_req;
  logic [7:0] or_rx_data;
  logic       ow_rx_valid;
  logic       ow_busy;
  logic       ow_rw;

  modport slave (
    input  iw_tx_data,
    output ow_tx_req, or_rx_data, ow_rx_valid, ow_busy, ow_rw
  );

  modport master (
    output iw_tx_data,
    input  ow_tx_req, or_rx_data, ow_rx_valid, ow_busy, ow_rw
  );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// I2C responder (7-bit address, no clock stretching).
// SCL is only sampled; SDA is open-drain (pulled low or released).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus free or not yet seen a START; SDA released
// ADDR      | shifting in address byte + R/W bit
// ADDR_ACK  | our address matched; drive ACK for one SCL period
// WRITE     | shifting in a data byte from the master
// WRITE_ACK | drive ACK for the byte just received
// READ      | shifting out a data byte to the master
// READ_ACK  | sample master ACK/NACK, reload on ACK
// IGNORE    | not for us (or master NACKed); wait for START/STOP
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h50
) (
  input  logic               iw_clk,
  input  logic               iw_reset,
  inout  wire                io_i2c_scl,
  inout  wire                io_i2c_sda,
  i2c_slave_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
  } state_t;

  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic       scl_rise, scl_fall, start_det, stop_det;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       sda_low;
  logic       ack_seen;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy, rw;

  // Open-drain output: the register resets asynchronously, so SDA lets go
  // the moment reset rises.
  assign io_i2c_sda = sda_low ? 1'b0 : 1'bz;

  assign bus.ow_tx_req   = tx_req;
  assign bus.or_rx_data  = rx_data;
  assign bus.ow_rx_valid = rx_valid;
  assign bus.ow_busy     = busy;
  assign bus.ow_rw       = rw;

  // Two-flop synchronizers plus a history flop for edge detection.
  always_ff @(posedge iw_clk or posedge iw_reset) begin
    if (iw_reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= io_i2c_scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= io_i2c_sda;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  // START/STOP require SCL high on both the current and previous sample so
  // an SCL fall coinciding with an SDA change is never mistaken for either.
  assign scl_rise  =  scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 &  scl_d;
  assign start_det =  scl_s2 &  scl_d &  sda_d & ~sda_s2;
  assign stop_det  =  scl_s2 &  scl_d & ~sda_d &  sda_s2;

  // Protocol FSM; every output is a register updated here.
  always_ff @(posedge iw_clk or posedge iw_reset) begin
    if (iw_reset) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      sda_low  <= 1'b0;
      ack_seen <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
      rw       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (stop_det) begin
        state    <= IDLE;
        sda_low  <= 1'b0;
        ack_seen <= 1'b0;
        busy     <= 1'b0;
      end else if (start_det) begin
        state    <= ADDR;
        sda_low  <= 1'b0;
        ack_seen <= 1'b0;
        bit_cnt  <= 3'd0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end
          ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_s2};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                // shift[6:0] holds the seven address bits; sda_s2 is R/W.
                if (shift[6:0] == SLAVE_ADDRESS) begin
                  rw    <= sda_s2;
                  busy  <= 1'b1;
                  state <= ADDR_ACK;
                end else begin
                  state <= IGNORE;
                end
              end
            end
          end
          ADDR_ACK: begin
            // First fall starts the ACK, second fall ends it.
            if (scl_fall) begin
              if (!sda_low) begin
                sda_low <= 1'b1;
              end else if (!rw) begin
                sda_low <= 1'b0;
                state   <= WRITE;
              end else begin
                // MSB goes out on this same fall; keep the rest left-aligned.
                shift   <= {bus.iw_tx_data[6:0], 1'b0};
                sda_low <= ~bus.iw_tx_data[7];
                tx_req  <= 1'b1;
                state   <= READ;
              end
            end
          end
          WRITE: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_s2};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= {shift[6:0], sda_s2};
                rx_valid <= 1'b1;
                state    <= WRITE_ACK;
              end
            end
          end
          WRITE_ACK: begin
            if (scl_fall) begin
              if (!sda_low) begin
                sda_low <= 1'b1;
              end else begin
                sda_low <= 1'b0;
                state   <= WRITE;
              end
            end
          end
          READ: begin
            if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                sda_low  <= 1'b0;
                ack_seen <= 1'b0;
                state    <= READ_ACK;
              end else begin
                sda_low <= ~shift[7];
                shift   <= {shift[6:0], 1'b0};
              end
            end
          end
          READ_ACK: begin
            if (scl_rise) begin
              if (sda_s2) begin
                state <= IGNORE;
              end else begin
                ack_seen <= 1'b1;
              end
            end else if (scl_fall && ack_seen) begin
              ack_seen <= 1'b0;
              shift    <= {bus.iw_tx_data[6:0], 1'b0};
              sda_low  <= ~bus.iw_tx_data[7];
              tx_req   <= 1'b1;
              state    <= READ;
            end
          end
          IGNORE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_slave_ctrl.md
I2C_SLAVE_CTRL -- requirements
Module: i2c_slave_ctrl

Interface
REQ-001 SHALL have parameter SLAVE_ADDRESS, default 7'h50, the 7-bit address this responder answers to.
REQ-002 SHALL have port iw_clk  input  1  system clock; frequency at least 10x the SCL rate.
REQ-003 SHALL have port iw_reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port io_i2c_scl  inout  1  I2C clock; sampled only, never driven (held at high-Z, no clock stretching).
REQ-005 SHALL have port io_i2c_sda  inout  1  I2C data; open-drain, driven to 0 or released to high-Z, never driven to 1.
REQ-006 SHALL have port iw_tx_data  input  8  byte returned to the master on the next read byte.
REQ-007 SHALL have port ow_tx_req  output  1  one-cycle pulse when iw_tx_data is captured.
REQ-008 SHALL have port or_rx_data  output  8  last byte written by the master.
REQ-009 SHALL have port ow_rx_valid  output  1  one-cycle pulse when or_rx_data updates.
REQ-010 SHALL have port ow_busy  output  1  high while this slave is addressed (ADDR_ACK through end of transfer).
REQ-011 SHALL have port ow_rw  output  1  R/W bit of the current addressed transfer (1 = read).

Function
REQ-012 SHALL pass SCL and SDA each through a 2-flop synchronizer plus one history flop; a pin transition becomes an internal edge event 3 iw_clk cycles later.
REQ-013 SHALL detect START as synced SDA falling while synced SCL high, and STOP as synced SDA rising while synced SCL high.
REQ-014 SHALL sample SDA only on SCL-rise events and change its SDA drive only on the cycle after an SCL-fall event.
REQ-015 SHALL implement the states IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK and IGNORE.
REQ-016 IDLE: SDA released; START -> ADDR with the bit counter set to 0.
REQ-017 ADDR: shift in 8 bits MSB first. After the 8th SCL rise, if bits[7:1] == SLAVE_ADDRESS, latch ow_rw = bit0 and go to ADDR_ACK; otherwise go to IGNORE without ever driving SDA.
REQ-018 ADDR_ACK: drive SDA low from the SCL fall after bit 8 until the next SCL fall.
- For a write (ow_rw = 0): then release SDA and go to WRITE.
- For a read (ow_rw = 1): capture iw_tx_data into the shift register and pulse ow_tx_req on the cycle of that fall, then go to READ.
REQ-019 WRITE: shift in 8 bits; on the 8th SCL rise, update or_rx_data and pulse ow_rx_valid for exactly 1 cycle, then go to WRITE_ACK.
REQ-020 WRITE_ACK: drive SDA low for one SCL period as in REQ-018, then return to WRITE for the next byte; every written byte SHALL be ACKed.
REQ-021 READ: present shift-register bits MSB first, each bit driven after the SCL fall (0 = drive low, 1 = release). After the 8th bit's SCL fall, release SDA and go to READ_ACK.
REQ-022 READ_ACK: sample SDA on the SCL rise.
- Master ACK (0): on the next SCL fall, capture iw_tx_data, pulse ow_tx_req and go to READ.
- Master NACK (1): go to IGNORE with SDA released.
REQ-023 IGNORE: SDA released; wait for START or STOP.
REQ-024 A STOP in any state SHALL release SDA and go to IDLE on the detection cycle, dropping ow_busy.
REQ-025 A START (including a repeated START) in any state SHALL release SDA, clear the bit counter and go to ADDR on the detection cycle.
REQ-026 If START/STOP coincides with an SCL edge event in the same cycle, START/STOP SHALL take priority.
REQ-027 The bit counter SHALL be 3 bits wide and wrap from 7 to 0 at each byte boundary; no other counter is needed.

Reset
REQ-028 While iw_reset is high: state = IDLE, SDA and SCL released (asynchronously, with no clock needed), or_rx_data = 8'h00, ow_rx_valid = 0, ow_tx_req = 0, ow_busy = 0, ow_rw = 0, synchronizer flops = 1.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer. After release, the block SHALL ignore bus activity until the next START.

Verification
REQ-030 Write to 7'h50 with data 8'hAA, then STOP -> SDA low in both ACK slots; or_rx_data = 8'hAA; exactly one ow_rx_valid pulse; ow_busy falls after STOP.
REQ-031 Read from 7'h50 with iw_tx_data = 8'hB1, master NACK -> SDA carries 1011_0001; one ow_tx_req pulse; SDA released after the NACK.
REQ-032 Address 7'h13, read and write -> SDA never driven low by the DUT; no ow_rx_valid or ow_tx_req pulse; ow_busy stays 0.
REQ-033 Write 8'h11 then 8'h22 to 7'h50 in one transfer -> two ow_rx_valid pulses carrying 8'h11 then 8'h22, three ACKs.
REQ-034 Write 8'h3C, then repeated START, then read (iw_tx_data = 8'h5A, master ACK then NACK) -> ow_rw goes 0 -> 1; two ow_tx_req pulses; bytes 8'h5A, 8'h5A on SDA.
REQ-035 iw_reset asserted while the DUT holds SDA low mid-read -> SDA released immediately; ow_busy = 0; no response until a new START.
